// File: rtl/alu_pkg.sv
// Shared ALU definitions for the byte-reduction (RED) execute unit:
// widths, FSM encoding and the byte sign-extension helper.
package alu_pkg;

   localparam int unsigned RED_ACC_W = 10;
   localparam int unsigned RED_BYTES = 4;
   localparam int unsigned RED_CNT_W = $clog2(RED_BYTES);
   localparam int unsigned RED_RES_W = 16;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      ACC  = 2'b01,
      DONE = 2'b10
   } red_state_e;

   function automatic logic [RED_ACC_W-1:0] sext10(input logic [7:0] data);
      return {{(RED_ACC_W - 8){data[7]}}, data};
   endfunction

endpackage

// File: rtl/red_byte_acc.sv
// Combinational accumulator step: acc + sext10(data), wrapping at 10 bits.
module red_byte_acc
   import alu_pkg::*;
(
   input  logic [RED_ACC_W-1:0] acc,
   input  logic [7:0]           data,
   output logic [RED_ACC_W-1:0] sum
);

   always_comb begin
      sum = acc + sext10(data);
   end

endmodule

// File: rtl/red_seq.sv
// Multi-cycle signed byte reduction of two 16-bit operands, one byte per cycle,
// with a start/busy/done handshake and a registered sign-extended result.
module red_seq
   import alu_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [15:0]          A,
   input  logic [15:0]          B,
   output logic                 busy,
   output logic                 done,
   output logic [RED_RES_W-1:0] Result
);

   red_state_e                 state_q, state_d;
   logic [15:0]                a_q, a_d;
   logic [15:0]                b_q, b_d;
   logic [RED_ACC_W-1:0]       acc_q, acc_d;
   logic [RED_CNT_W-1:0]       cnt_q, cnt_d;
   logic [RED_RES_W-1:0]       result_q, result_d;
   logic [7:0]                 cur_byte;
   logic [RED_ACC_W-1:0]       acc_sum;

   always_comb begin
      cur_byte = a_q[7:0];
      unique case (cnt_q)
         2'd0: cur_byte = a_q[7:0];
         2'd1: cur_byte = a_q[15:8];
         2'd2: cur_byte = b_q[7:0];
         2'd3: cur_byte = b_q[15:8];
      endcase
   end

   red_byte_acc u_acc (
      .acc  (acc_q),
      .data (cur_byte),
      .sum  (acc_sum)
   );

   always_comb begin
      state_d  = state_q;
      a_d      = a_q;
      b_d      = b_q;
      acc_d    = acc_q;
      cnt_d    = cnt_q;
      result_d = result_q;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               a_d     = A;
               b_d     = B;
               acc_d   = '0;
               cnt_d   = '0;
               state_d = ACC;
            end
         end
         ACC: begin
            // start is deliberately ignored here: no re-capture, no queueing
            acc_d = acc_sum;
            cnt_d = cnt_q + RED_CNT_W'(1);
            if (cnt_q == RED_CNT_W'(RED_BYTES - 1)) begin
               state_d  = DONE;
               result_d = {{(RED_RES_W - RED_ACC_W){acc_sum[RED_ACC_W-1]}}, acc_sum};
            end
         end
         DONE: begin
            if (start) begin
               a_d     = A;
               b_d     = B;
               acc_d   = '0;
               cnt_d   = '0;
               state_d = ACC;
            end else begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         a_q      <= '0;
         b_q      <= '0;
         acc_q    <= '0;
         cnt_q    <= '0;
         result_q <= '0;
      end else begin
         state_q  <= state_d;
         a_q      <= a_d;
         b_q      <= b_d;
         acc_q    <= acc_d;
         cnt_q    <= cnt_d;
         result_q <= result_d;
      end
   end

   // Outputs decode registered state only; no input-to-output path.
   assign busy   = (state_q == ACC);
   assign done   = (state_q == DONE);
   assign Result = result_q;

endmodule
